// File: rtl/tiny_dnn_pool_pkg.sv
// Shared types and helpers for the streaming 2x2 max-pool block.
// Optional argmax datapath is enabled by defining TINY_DNN_POOL_ARGMAX_EN.
package tiny_dnn_pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2
  } state_t;

  localparam int PTR_W = 16;

  // A plane is legal if it has at least one row pair and whole beats per row.
  function automatic logic cfg_ok(input int iw, input int ih, input int lanes, input int max_w);
    return (iw != 0) && (ih >= 2) && (iw <= max_w) && ((iw % lanes) == 0);
  endfunction

endpackage

// File: rtl/tiny_dnn_pool_cmp.sv
// Two-input signed max with optional argmax; operand a is the earlier pixel,
// so ties keep a. Argmax ports exist only with TINY_DNN_POOL_ARGMAX_EN.
module tiny_dnn_pool_cmp
  import tiny_dnn_pool_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a_val,
  input  logic signed [DATA_W-1:0] b_val,
`ifdef TINY_DNN_POOL_ARGMAX_EN
  input  logic [PTR_W-1:0]         a_ptr,
  input  logic [PTR_W-1:0]         b_ptr,
  output logic [PTR_W-1:0]         y_ptr,
`endif
  output logic signed [DATA_W-1:0] y_val
);

  logic take_b;

  assign take_b = b_val > a_val;
  assign y_val  = take_b ? b_val : a_val;

`ifdef TINY_DNN_POOL_ARGMAX_EN
  assign y_ptr  = take_b ? b_ptr : a_ptr;
`endif

endmodule

// File: rtl/tiny_dnn_pool_stream.sv
// Streaming 2x2 stride-2 max pooling over a row-major plane, LANES pixels per beat.
// TINY_DNN_POOL_ARGMAX_EN adds the per-output argmax pointer on dst_ptr.
module tiny_dnn_pool_stream
  import tiny_dnn_pool_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int MAX_W  = 32,
  parameter int DIM_W  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIM_W-1:0]            iw,
  input  logic [DIM_W-1:0]            ih,
  input  logic                        src_valid,
  input  logic [LANES*DATA_W-1:0]     src_data,
  input  logic                        src_last,
  output logic                        src_ready,
  output logic                        dst_valid,
  output logic [LANES/2*DATA_W-1:0]   dst_data,
  output logic [LANES/2*PTR_W-1:0]    dst_ptr,
  output logic                        dst_last,
  input  logic                        dst_ready,
  output logic                        busy,
  output logic                        p_fin,
  output logic                        err
);

  localparam int OL     = LANES / 2;
  localparam int NBEATS = MAX_W / LANES;
  localparam int BC_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LG_L   = $clog2(LANES);

  state_t state, state_nx;

  logic [DIM_W-1:0]     bpr;
  logic [DIM_W-1:0]     beat_cnt;
  logic [DIM_W-1:0]     rows_left;
  logic [BC_W-1:0]      beat_idx;
  logic                 in_done, in_done_nx;
  logic                 dst_valid_nx;
  logic                 accept, row_end, final_beat, cfg_good, start_take, fin;

  logic [OL*DATA_W-1:0] lb_val [NBEATS];
  logic [OL*DATA_W-1:0] top_val;
  logic [OL*DATA_W-1:0] h_val;
  logic [OL*DATA_W-1:0] v_val;

`ifdef TINY_DNN_POOL_ARGMAX_EN
  logic [PTR_W-1:0]     ptr_cnt;
  logic [OL*PTR_W-1:0]  lb_ptr [NBEATS];
  logic [OL*PTR_W-1:0]  top_ptr;
  logic [OL*PTR_W-1:0]  h_ptr;
  logic [OL*PTR_W-1:0]  v_ptr;
`endif

  assign beat_idx   = beat_cnt[BC_W-1:0];
  assign accept     = src_valid & src_ready;
  assign row_end    = (beat_cnt == bpr - DIM_W'(1));
  assign final_beat = row_end && (rows_left == DIM_W'(1));
  assign cfg_good   = cfg_ok(int'(iw), int'(ih), LANES, MAX_W);
  assign start_take = start && !busy;
  assign top_val    = lb_val[beat_idx];

  // Stage h pairs columns within the current beat; stage v folds in the stored top row.
  for (genvar k = 0; k < OL; k++) begin : g_lane
    tiny_dnn_pool_cmp #(.DATA_W(DATA_W)) u_h (
      .a_val (src_data[(2*k)*DATA_W +: DATA_W]),
      .b_val (src_data[(2*k+1)*DATA_W +: DATA_W]),
`ifdef TINY_DNN_POOL_ARGMAX_EN
      .a_ptr (ptr_cnt + PTR_W'(2*k)),
      .b_ptr (ptr_cnt + PTR_W'(2*k+1)),
      .y_ptr (h_ptr[k*PTR_W +: PTR_W]),
`endif
      .y_val (h_val[k*DATA_W +: DATA_W])
    );

    tiny_dnn_pool_cmp #(.DATA_W(DATA_W)) u_v (
      .a_val (top_val[k*DATA_W +: DATA_W]),
      .b_val (h_val[k*DATA_W +: DATA_W]),
`ifdef TINY_DNN_POOL_ARGMAX_EN
      .a_ptr (top_ptr[k*PTR_W +: PTR_W]),
      .b_ptr (h_ptr[k*PTR_W +: PTR_W]),
      .y_ptr (v_ptr[k*PTR_W +: PTR_W]),
`endif
      .y_val (v_val[k*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_nx     = state;
    src_ready    = 1'b0;
    dst_valid_nx = dst_valid;
    case (state)
      S_IDLE: begin
        if (start_take && cfg_good) state_nx = S_EVEN;
      end
      S_EVEN: begin
        src_ready = 1'b1;
        if (accept && row_end) state_nx = (rows_left == DIM_W'(1)) ? S_IDLE : S_ODD;
      end
      S_ODD: begin
        src_ready = ~dst_valid | dst_ready;
        if (accept && row_end) state_nx = (rows_left == DIM_W'(1)) ? S_IDLE : S_EVEN;
      end
      default: state_nx = S_IDLE;
    endcase
    if (dst_valid && dst_ready) dst_valid_nx = 1'b0;
    if (state == S_ODD && accept) dst_valid_nx = 1'b1;
  end

  // Completion needs both the last input beat and an empty output register.
  assign in_done_nx = in_done | (accept & final_beat);
  assign fin        = busy && in_done_nx && !dst_valid_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bpr       <= '0;
      beat_cnt  <= '0;
      rows_left <= '0;
      in_done   <= 1'b0;
      busy      <= 1'b0;
      p_fin     <= 1'b0;
      err       <= 1'b0;
      dst_valid <= 1'b0;
      dst_last  <= 1'b0;
      dst_data  <= '0;
    end else begin
      state     <= state_nx;
      dst_valid <= dst_valid_nx;
      in_done   <= in_done_nx;
      p_fin     <= fin;
      if (fin) busy <= 1'b0;

      if (start_take) begin
        if (cfg_good) begin
          err       <= 1'b0;
          busy      <= 1'b1;
          bpr       <= iw >> LG_L;
          rows_left <= ih;
          beat_cnt  <= '0;
          in_done   <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end

      // Framing mismatches are flagged but counting follows the latched config.
      if (accept) begin
        if (src_last != final_beat) err <= 1'b1;
        if (row_end) begin
          beat_cnt  <= '0;
          rows_left <= rows_left - DIM_W'(1);
        end else begin
          beat_cnt  <= beat_cnt + DIM_W'(1);
        end
      end

      if (state == S_ODD && accept) begin
        dst_data <= v_val;
        dst_last <= row_end && (rows_left <= DIM_W'(2));
      end else if (dst_valid && dst_ready) begin
        dst_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_EVEN && accept) lb_val[beat_idx] <= h_val;
  end

`ifdef TINY_DNN_POOL_ARGMAX_EN
  assign top_ptr = lb_ptr[beat_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_cnt <= '0;
      dst_ptr <= '0;
    end else begin
      if (start_take && cfg_good) ptr_cnt <= '0;
      else if (accept) ptr_cnt <= ptr_cnt + PTR_W'(LANES);
      if (state == S_ODD && accept) dst_ptr <= v_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_EVEN && accept) lb_ptr[beat_idx] <= h_ptr;
  end
`else
  assign dst_ptr = '0;
`endif

endmodule

// File: tb/tb_tiny_dnn_pool_stream.sv
// Scoreboard bench for tiny_dnn_pool_stream: expected beats are queued as
// odd-row input is driven and popped when the output handshake occurs.
module tb_tiny_dnn_pool_stream;

  localparam int L  = 4;
  localparam int DW = 16;
  localparam int OL = L / 2;

  typedef struct {
    logic [OL*DW-1:0] d;
    logic [OL*16-1:0] p;
    logic             last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, start, src_valid, src_last, src_ready;
  logic [5:0]        iw, ih;
  logic [L*DW-1:0]   src_data;
  logic              dst_valid, dst_last, dst_ready, busy, p_fin, err;
  logic [OL*DW-1:0]  dst_data;
  logic [OL*16-1:0]  dst_ptr;

  exp_t              sb[$];
  logic signed [DW-1:0] pix [0:7][0:31];
  int                n_chk = 0;
  int                n_fail = 0;
  int                fin_cnt = 0;
  int                ready_mode = 0;
  logic              hold_v = 1'b0;
  logic [OL*DW-1:0]  hold_d;

  tiny_dnn_pool_stream #(.LANES(L), .DATA_W(DW), .MAX_W(32), .DIM_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .iw(iw), .ih(ih),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ptr(dst_ptr), .dst_last(dst_last),
    .dst_ready(dst_ready), .busy(busy), .p_fin(p_fin), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       dst_ready = 1'($urandom_range(0, 1));
      2:       dst_ready = 1'b0;
      default: dst_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("hold_data", dst_data, hold_d);
      if (dst_valid && dst_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dst_data", dst_data, e.d);
          check("dst_ptr", dst_ptr, e.p);
          check("dst_last", dst_last, e.last);
        end
      end
      hold_v = dst_valid && !dst_ready;
      hold_d = dst_data;
      if (p_fin) begin
        fin_cnt++;
        check("fin_sb_empty", sb.size(), 0);
        check("fin_busy_low", busy, 0);
      end
    end
  end

  function automatic logic [L*DW-1:0] beat_data(input int y, input int b);
    logic [L*DW-1:0] d;
    for (int j = 0; j < L; j++) d[j*DW +: DW] = pix[y][b*L + j];
    return d;
  endfunction

  // Reference for the pool window under odd row y, beat b.
  function automatic exp_t model(input int y, input int b, input int w, input int h);
    exp_t r;
    for (int k = 0; k < OL; k++) begin
      int x0 = b*L + 2*k;
      logic signed [DW-1:0] best;
      int bp;
      best = pix[y-1][x0];
      bp   = (y-1)*w + x0;
      for (int c = 1; c < 4; c++) begin
        int yy = y - 1 + c/2;
        int xx = x0 + c%2;
        if (pix[yy][xx] > best) begin
          best = pix[yy][xx];
          bp   = yy*w + xx;
        end
      end
      r.d[k*DW +: DW] = best;
`ifdef TINY_DNN_POOL_ARGMAX_EN
      r.p[k*16 +: 16] = 16'(bp);
`else
      r.p[k*16 +: 16] = 16'd0;
`endif
    end
    r.last = (y == 2*(h/2) - 1) && (b == w/L - 1);
    return r;
  endfunction

  task automatic drive_beat(input logic [L*DW-1:0] d, input logic last);
    int n = 0;
    logic got;
    src_valid = 1'b1;
    src_data  = d;
    src_last  = last;
    forever begin
      @(negedge clk);
      got = src_ready;
      tick;
      if (got) break;
      n++;
      if (n > 1000) begin
        check("beat_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic fill_pix(input int mode);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 32; x++) begin
        int v = int'($urandom_range(0, 15)) - 8;
        pix[y][x] = (mode == 1) ? 16'sd9 : v[DW-1:0];
      end
  endtask

  task automatic run_plane(input int w, input int h, input bit bad_last, input bit mid_start);
    int fin0 = fin_cnt;
    int n = 0;
    start = 1'b1;
    iw = 6'(w);
    ih = 6'(h);
    tick;
    start = 1'b0;
    check("start_err_clear", err, 0);
    check("start_busy", busy, 1);
    for (int y = 0; y < h; y++)
      for (int b = 0; b < w/L; b++) begin
        logic last;
        if (ready_mode == 1 && $urandom_range(0, 3) == 0) begin
          src_valid = 1'b0;
          tick;
        end
        last = ((y == h-1) && (b == w/L-1)) ^ (bad_last && y == 0 && b == 0);
        if ((y % 2 == 1)) sb.push_back(model(y, b, w, h));
        if (mid_start && y == 1 && b == 0) begin
          start = 1'b1;
          iw = 6'd6;
          ih = 6'd1;
        end
        drive_beat(beat_data(y, b), last);
        start = 1'b0;
      end
    src_valid = 1'b0;
    src_last  = 1'b0;
    while (fin_cnt == fin0) begin
      tick;
      n++;
      if (n > 2000) begin
        check("fin_timeout", 1, 0);
        break;
      end
    end
    repeat (3) tick;
    check("fin_once", fin_cnt, fin0 + 1);
    check("err_end", err, bad_last);
    check("src_ready_idle", src_ready, 0);
  endtask

  task automatic stall_thread;
    int n = 0;
    while (!dst_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall_saw_valid", dst_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_src_ready", src_ready, 0);
      check("stall_dst_valid", dst_valid, 1);
    end
    ready_mode = 0;
  endtask

  initial begin
    int bad_w[4] = '{6, 0, 4, 36};
    int bad_h[4] = '{2, 2, 1, 2};
    int ws[4]    = '{4, 8, 16, 32};
    rst = 1'b1; start = 1'b0; iw = '0; ih = '0;
    src_valid = 1'b0; src_data = '0; src_last = 1'b0; dst_ready = 1'b1;
    repeat (3) tick;
    check("rst_src_ready", src_ready, 0);
    check("rst_dst_valid", dst_valid, 0);
    check("rst_dst_last", dst_last, 0);
    check("rst_busy", busy, 0);
    check("rst_p_fin", p_fin, 0);
    check("rst_err", err, 0);
    check("rst_dst_data", dst_data, 0);
    check("rst_dst_ptr", dst_ptr, 0);
    rst = 1'b0;
    tick;

    // Directed example plane.
    fill_pix(0);
    pix[0][0] = 16'sd1; pix[0][1] = 16'sd5; pix[0][2] = 16'sd3; pix[0][3] = 16'sd2;
    pix[1][0] = 16'sd4; pix[1][1] = 16'sd0; pix[1][2] = 16'sd7; pix[1][3] = 16'sd7;
    run_plane(4, 2, 0, 0);

    fill_pix(1);
    run_plane(8, 4, 0, 0);

    fill_pix(0);
    ready_mode = 2;
    fork
      run_plane(8, 2, 0, 0);
      stall_thread();
    join

    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      iw = 6'(bad_w[i]);
      ih = 6'(bad_h[i]);
      tick;
      start = 1'b0;
      tick;
      check("bad_cfg_err", err, 1);
      check("bad_cfg_busy", busy, 0);
      check("bad_cfg_src_ready", src_ready, 0);
      fill_pix(0);
      run_plane(4, 2, 0, 0);
    end

    fill_pix(0);
    run_plane(4, 3, 0, 0);

    // Reset in the middle of an odd row.
    fill_pix(0);
    ready_mode = 2;
    start = 1'b1; iw = 6'd8; ih = 6'd4;
    tick;
    start = 1'b0;
    drive_beat(beat_data(0, 0), 1'b0);
    drive_beat(beat_data(0, 1), 1'b0);
    drive_beat(beat_data(1, 0), 1'b0);
    src_valid = 1'b0;
    check("pre_rst_valid", dst_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_dst_valid", dst_valid, 0);
    check("mid_rst_src_ready", src_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dst_data", dst_data, 0);
    check("mid_rst_dst_ptr", dst_ptr, 0);
    check("mid_rst_dst_last", dst_last, 0);
    tick;
    rst = 1'b0;
    sb.delete();
    ready_mode = 0;
    tick;
    fill_pix(0);
    run_plane(8, 2, 0, 0);

    fill_pix(0);
    run_plane(8, 2, 1, 0);
    fill_pix(0);
    run_plane(8, 4, 0, 1);

    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      fill_pix(0);
      run_plane(ws[$urandom_range(0, 3)], int'($urandom_range(2, 5)), 0, 0);
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
